// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between
// the 6502 core (A) and the loader/debug port (B), with bounded locked bursts.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic {OPEN, LOCKED} state_t;
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);
  state_t     state_q, state_d;
  logic       owner_q, owner_d, last_q, last_d;
  logic       a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       own_req, own_lock, oth_req, arb;
  // owner/last encode B as 1; arb means plain round-robin applies this cycle
  always_comb begin
    own_req  = owner_q ? b_req : a_req;
    own_lock = owner_q ? b_lock : a_lock;
    oth_req  = owner_q ? a_req : b_req;
    arb      = (state_q == OPEN) || (oth_req && lock_cnt_q >= LOCK_MAX_C);
    a_gnt    = arb ? a_req & (~b_req | last_q) : ~owner_q & a_req;
    b_gnt    = arb ? b_req & (~a_req | ~last_q) : owner_q & b_req;
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (arb) begin
      state_d = OPEN;
      if (a_gnt | b_gnt) begin
        last_d = b_gnt;
        if (b_gnt ? b_lock : a_lock) begin
          state_d    = LOCKED;
          owner_d    = b_gnt;
          lock_cnt_d = 8'd1;
        end
      end
    end else if (own_req) begin
      if (own_lock) lock_cnt_d = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;
      else state_d = OPEN;
    end
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    mem_en     = a_gnt | b_gnt;
    mem_we     = b_gnt ? b_we : a_gnt & a_we;
    mem_addr   = b_gnt ? b_addr : a_addr;
    mem_wdata  = b_gnt ? b_wdata : a_wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OPEN;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rdata    = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks against a behavioural memory, with
// expected read data queued per port at grant time and popped on rvalid.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [15:0] a_addr, b_addr, mem_addr;
  logic [7:0]  a_wdata, b_wdata, rdata, mem_wdata, mem_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  aq[$], bq[$];
  logic        exp_arv, exp_brv;
  int          vec = 0, errs = 0;

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic idle();
    a_req = 0; a_lock = 0; a_we = 0; a_addr = 16'h0; a_wdata = 8'h0;
    b_req = 0; b_lock = 0; b_we = 0; b_addr = 16'h0; b_wdata = 8'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    exp_arv = 0; exp_brv = 0;
    aq.delete(); bq.delete();
    @(posedge clk); @(negedge clk);
    reset = 0;
  endtask

  // Record the expected consequences of this cycle's grants, then move to the next negedge.
  task automatic advance(input logic ea, input logic eb);
    exp_arv = ea & ~a_we;
    exp_brv = eb & ~b_we;
    if (exp_arv) aq.push_back(ref_mem[a_addr]);
    if (exp_brv) bq.push_back(ref_mem[b_addr]);
    if (ea & a_we) ref_mem[a_addr] = a_wdata;
    if (eb & b_we) ref_mem[b_addr] = b_wdata;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #1;
    vec++;
    if ({a_gnt, b_gnt, mem_en, mem_we, a_rvalid, b_rvalid} !== 6'b0) begin
      errs++;
      $display("FAIL reset_outputs: got gnt=%b%b en=%b we=%b rv=%b%b, expected all 0",
               a_gnt, b_gnt, mem_en, mem_we, a_rvalid, b_rvalid);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      a_req = (i == 0); a_addr = 16'h1234;
      #1;
      vec++;
      if ({a_gnt, b_gnt, mem_en} !== {i == 0, 1'b0, i == 0}) begin
        errs++;
        $display("FAIL single_gnt cycle %0d: got a=%b b=%b en=%b, expected a=%b b=0 en=%b",
                 i, a_gnt, b_gnt, mem_en, i == 0, i == 0);
      end
      if (i == 0) begin
        vec++;
        if (mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
          errs++;
          $display("FAIL single_drive: got addr=%h we=%b, expected addr=1234 we=0", mem_addr, mem_we);
        end
      end
      vec++;
      if (a_rvalid !== exp_arv || b_rvalid !== exp_brv) begin
        errs++;
        $display("FAIL single_rvalid cycle %0d: got a=%b b=%b, expected a=%b b=%b",
                 i, a_rvalid, b_rvalid, exp_arv, exp_brv);
      end
      if (exp_arv) begin
        e = aq.pop_front();
        vec++;
        if (rdata !== e || rdata !== 8'h5A) begin
          errs++;
          $display("FAIL single_rdata: got %h, expected 5a", rdata);
        end
      end
      advance(i == 0, 1'b0);
    end
  endtask

  task automatic test_alternate();
    logic ea, eb;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      a_req = (i < 8); b_req = (i < 8);
      a_addr = 16'h0010 + 16'(i); b_addr = 16'h0080 + 16'(i);
      ea = (i < 8) && (i % 2 == 0);
      eb = (i < 8) && (i % 2 == 1);
      #1;
      vec++;
      if ({a_gnt, b_gnt} !== {ea, eb}) begin
        errs++;
        $display("FAIL alt_gnt cycle %0d: got a=%b b=%b, expected a=%b b=%b", i, a_gnt, b_gnt, ea, eb);
      end
      vec++;
      if (mem_en !== (ea | eb) || mem_addr !== (eb ? b_addr : a_addr)) begin
        errs++;
        $display("FAIL alt_drive cycle %0d: got en=%b addr=%h, expected en=%b addr=%h",
                 i, mem_en, mem_addr, ea | eb, eb ? b_addr : a_addr);
      end
      vec++;
      if (a_rvalid !== exp_arv || b_rvalid !== exp_brv) begin
        errs++;
        $display("FAIL alt_rvalid cycle %0d: got a=%b b=%b, expected a=%b b=%b",
                 i, a_rvalid, b_rvalid, exp_arv, exp_brv);
      end
      if (exp_arv || exp_brv) begin
        e = exp_arv ? aq.pop_front() : bq.pop_front();
        vec++;
        if (rdata !== e) begin
          errs++;
          $display("FAIL alt_rdata cycle %0d: got %h, expected %h", i, rdata, e);
        end
      end
      advance(ea, eb);
    end
  endtask

  task automatic test_lock_burst();
    logic ea, eb;
    logic [7:0] e;
    int k = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i < 7) begin
        a_req = (i <= 5); a_addr = 16'h0011;
        b_req = (i >= 1) && (k < 4); b_we = 1; b_lock = (k < 3);
        b_addr = 16'hC000 + 16'(k); b_wdata = 8'hB0 + 8'(k);
        ea = (i == 0) || (i == 5);
        eb = (i >= 1) && (i <= 4);
      end else begin
        a_req = (i < 11); a_addr = 16'hC000 + 16'(i - 7);
        ea = (i < 11); eb = 0;
      end
      #1;
      vec++;
      if ({a_gnt, b_gnt} !== {ea, eb}) begin
        errs++;
        $display("FAIL burst_gnt cycle %0d: got a=%b b=%b, expected a=%b b=%b", i, a_gnt, b_gnt, ea, eb);
      end
      if (eb) begin
        vec++;
        if (mem_we !== 1'b1 || mem_addr !== b_addr || mem_wdata !== b_wdata) begin
          errs++;
          $display("FAIL burst_write cycle %0d: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                   i, mem_we, mem_addr, mem_wdata, b_addr, b_wdata);
        end
      end
      vec++;
      if (a_rvalid !== exp_arv || b_rvalid !== exp_brv) begin
        errs++;
        $display("FAIL burst_rvalid cycle %0d: got a=%b b=%b, expected a=%b b=%b",
                 i, a_rvalid, b_rvalid, exp_arv, exp_brv);
      end
      if (exp_arv) begin
        e = aq.pop_front();
        vec++;
        if (rdata !== e) begin
          errs++;
          $display("FAIL burst_rdata cycle %0d: got %h, expected %h", i, rdata, e);
        end
      end
      advance(ea, eb);
      if (eb) k++;
    end
  endtask

  task automatic test_lock_max();
    logic ea, eb;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      idle();
      b_req = (i < 14); b_lock = 1; b_addr = 16'h0020;
      a_req = (i >= 1) && (i < 14); a_addr = 16'h0030;
      ea = (i < 14) && (i % 5 == 4);
      eb = (i < 14) && (i % 5 != 4);
      #1;
      vec++;
      if ({a_gnt, b_gnt} !== {ea, eb}) begin
        errs++;
        $display("FAIL lockmax_gnt cycle %0d: got a=%b b=%b, expected a=%b b=%b", i, a_gnt, b_gnt, ea, eb);
      end
      vec++;
      if (a_rvalid !== exp_arv || b_rvalid !== exp_brv) begin
        errs++;
        $display("FAIL lockmax_rvalid cycle %0d: got a=%b b=%b, expected a=%b b=%b",
                 i, a_rvalid, b_rvalid, exp_arv, exp_brv);
      end
      if (exp_arv || exp_brv) begin
        e = exp_arv ? aq.pop_front() : bq.pop_front();
        vec++;
        if (rdata !== e) begin
          errs++;
          $display("FAIL lockmax_rdata cycle %0d: got %h, expected %h", i, rdata, e);
        end
      end
      advance(ea, eb);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      a_req = (i < 2); a_we = (i == 0); a_addr = 16'h0200; a_wdata = 8'h77;
      #1;
      vec++;
      if (a_gnt !== (i < 2) || mem_we !== (i == 0)) begin
        errs++;
        $display("FAIL wr_gnt cycle %0d: got gnt=%b we=%b, expected gnt=%b we=%b",
                 i, a_gnt, mem_we, i < 2, i == 0);
      end
      if (i == 0) begin
        vec++;
        if (mem_addr !== 16'h0200 || mem_wdata !== 8'h77) begin
          errs++;
          $display("FAIL wr_drive: got addr=%h data=%h, expected addr=0200 data=77", mem_addr, mem_wdata);
        end
      end
      vec++;
      if (a_rvalid !== exp_arv || b_rvalid !== 1'b0) begin
        errs++;
        $display("FAIL wr_rvalid cycle %0d: got a=%b b=%b, expected a=%b b=0", i, a_rvalid, b_rvalid, exp_arv);
      end
      if (exp_arv) begin
        e = aq.pop_front();
        vec++;
        if (rdata !== e || rdata !== 8'h77) begin
          errs++;
          $display("FAIL wr_rdata: got %h, expected 77", rdata);
        end
      end
      advance(i < 2, 1'b0);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      b_req = 1; b_lock = 1; b_addr = 16'h0040 + 16'(i);
      #1;
      vec++;
      if ({a_gnt, b_gnt} !== 2'b01 || b_rvalid !== (i == 1)) begin
        errs++;
        $display("FAIL inflight_pre cycle %0d: got a=%b b=%b brv=%b, expected a=0 b=1 brv=%b",
                 i, a_gnt, b_gnt, b_rvalid, i == 1);
      end
      if (i == 0) advance(1'b0, 1'b1);
    end
    reset = 1;
    exp_brv = 0; bq.delete();
    #1;
    vec++;
    if (b_gnt !== 1'b1 || b_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL inflight_async: got b_gnt=%b b_rvalid=%b, expected b_gnt=1 b_rvalid=0", b_gnt, b_rvalid);
    end
    @(posedge clk); @(negedge clk);
    idle();
    #1;
    vec++;
    if ({b_rvalid, a_rvalid, mem_en} !== 3'b000) begin
      errs++;
      $display("FAIL inflight_rvalid: got brv=%b arv=%b en=%b, expected 0 0 0", b_rvalid, a_rvalid, mem_en);
    end
    reset = 0;
    @(negedge clk);
    a_req = 1; b_req = 1; a_addr = 16'h0050; b_addr = 16'h0060;
    #1;
    vec++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errs++;
      $display("FAIL inflight_after: got a=%b b=%b, expected a=1 b=0", a_gnt, b_gnt);
    end
    advance(1'b1, 1'b0);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = mem[i];
    end
    mem[16'h1234] = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    mem_rdata = 8'h0;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_lock_max();
    test_write_read();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
